// File: rtl/t_pulse_gen.sv
// Button conditioner: synchronizer, debounce FSM, single-cycle toggle pulse and pulse counter.
// Optional feature: define AUTO_REPEAT_EN for repeat pulses while the button is held.
module t_pulse_gen #(
    parameter int SYNC_STAGES = 2,
    parameter int DB_CYCLES   = 16,
    parameter int REPEAT_DLY  = 64,
    parameter int REPEAT_PER  = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_in,
    output logic       t,
    output logic       pressed,
    output logic [7:0] pulse_cnt
);

    typedef enum logic [1:0] {
        IDLE,
        DB_PRESS,
        HELD,
        DB_REL
    } state_t;

    localparam logic [7:0] DB_LAST = 8'(DB_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   btn_s;

    state_t     state_q, state_d;
    logic [7:0] db_q, db_d;
    logic       t_d;
    logic       pressed_d;

    assign btn_s = sync_q[SYNC_STAGES-1];

`ifdef AUTO_REPEAT_EN
    localparam logic [15:0] DLY_LAST = 16'(REPEAT_DLY - 1);
    localparam logic [15:0] PER_LAST = 16'(REPEAT_PER - 1);

    logic [15:0] rpt_q, rpt_d;
    logic        rpt_run_q, rpt_run_d;
    logic [15:0] rpt_lim;
`endif

    always_comb begin
        state_d   = state_q;
        db_d      = db_q;
        t_d       = 1'b0;
        pressed_d = pressed;
        unique case (state_q)
            IDLE: begin
                if (btn_s) begin
                    state_d = DB_PRESS;
                    db_d    = 8'd0;
                end
            end
            DB_PRESS: begin
                if (!btn_s) begin
                    state_d = IDLE;
                end else if (db_q == DB_LAST) begin
                    state_d   = HELD;
                    pressed_d = 1'b1;
                    t_d       = 1'b1;
                end else begin
                    db_d = db_q + 8'd1;
                end
            end
            HELD: begin
                if (!btn_s) begin
                    state_d = DB_REL;
                    db_d    = 8'd0;
                end
            end
            DB_REL: begin
                if (btn_s) begin
                    state_d = HELD;
                end else if (db_q == DB_LAST) begin
                    state_d   = IDLE;
                    pressed_d = 1'b0;
                end else begin
                    db_d = db_q + 8'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

`ifdef AUTO_REPEAT_EN
        rpt_d     = 16'd0;
        rpt_run_d = 1'b0;
        rpt_lim   = rpt_run_q ? PER_LAST : DLY_LAST;
        if (state_q == HELD && btn_s) begin
            rpt_d     = rpt_q;
            rpt_run_d = rpt_run_q;
            // A repeat due right after a pulse waits one cycle so t never stays high.
            if (rpt_q == rpt_lim) begin
                if (!t) begin
                    t_d       = 1'b1;
                    rpt_d     = 16'd0;
                    rpt_run_d = 1'b1;
                end
            end else begin
                rpt_d = rpt_q + 16'd1;
            end
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q    <= '0;
            state_q   <= IDLE;
            db_q      <= 8'd0;
            t         <= 1'b0;
            pressed   <= 1'b0;
            pulse_cnt <= 8'd0;
        end else begin
            sync_q    <= {sync_q[SYNC_STAGES-2:0], btn_in};
            state_q   <= state_d;
            db_q      <= db_d;
            t         <= t_d;
            pressed   <= pressed_d;
            pulse_cnt <= pulse_cnt + {7'd0, t_d};
        end
    end

`ifdef AUTO_REPEAT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rpt_q     <= 16'd0;
            rpt_run_q <= 1'b0;
        end else begin
            rpt_q     <= rpt_d;
            rpt_run_q <= rpt_run_d;
        end
    end
`endif

endmodule

// File: tb/tb_t_pulse_gen.sv
// Directed bench for t_pulse_gen; edges are numbered from 0 after each reset release.
// Build with AUTO_REPEAT_EN defined to check the repeat pulse train.
module tb_t_pulse_gen;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       btn_in = 1'b0;
    logic       t;
    logic       pressed;
    logic [7:0] pulse_cnt;

    int checks = 0;
    int fails = 0;
    int ecnt = -1;
    int t_edges[$];
    int back_to_back = 0;
    logic t_prev = 1'b0;

    t_pulse_gen dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .btn_in    (btn_in),
        .t         (t),
        .pressed   (pressed),
        .pulse_cnt (pulse_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        assert (got === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        ecnt++;
        if (t === 1'b1) t_edges.push_back(ecnt);
        if (t === 1'b1 && t_prev === 1'b1) back_to_back++;
        t_prev = t;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #12;
        @(negedge clk);
        rst_n = 1'b1;
        ecnt = -1;
        t_prev = 1'b0;
        t_edges.delete();
    endtask

    int exp_edges[$];

    initial begin
        do_reset();
        check("reset_t", t, 0);
        check("reset_pressed", pressed, 0);
        check("reset_cnt", pulse_cnt, 0);

        // Clean press: high sampled at edges 10..49
        for (int e = 0; e <= 75; e++) begin
            tick();
            check("p1_t", t, (ecnt == 28) ? 1 : 0);
            check("p1_pressed", pressed, (ecnt >= 28 && ecnt <= 67) ? 1 : 0);
            if (ecnt == 9) btn_in = 1'b1;
            if (ecnt == 49) btn_in = 1'b0;
        end
        check("p1_cnt", pulse_cnt, 1);

        // Short glitch, shorter than the debounce window
        t_edges.delete();
        btn_in = 1'b1;
        ticks(10);
        btn_in = 1'b0;
        ticks(30);
        check("glitch_pulses", t_edges.size(), 0);
        check("glitch_pressed", pressed, 0);
        check("glitch_cnt", pulse_cnt, 1);

        // Release bounce while held
        t_edges.delete();
        btn_in = 1'b1;
        ticks(25);
        check("held_pressed", pressed, 1);
        check("held_cnt", pulse_cnt, 2);
        btn_in = 1'b0;
        ticks(5);
        btn_in = 1'b1;
        for (int i = 0; i < 30; i++) begin
            tick();
            check("bounce_pressed", pressed, 1);
        end
        check("bounce_pulses", t_edges.size(), 1);
        check("bounce_cnt", pulse_cnt, 2);
        btn_in = 1'b0;
        ticks(30);
        check("bounce_release", pressed, 0);

        // Reset in DB_PRESS with db_cnt=8, button still held
        btn_in = 1'b1;
        ticks(11);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_t", t, 0);
        check("mid_rst_pressed", pressed, 0);
        check("mid_rst_cnt", pulse_cnt, 0);
        @(negedge clk);
        rst_n = 1'b1;
        ecnt = -1;
        t_prev = 1'b0;
        t_edges.delete();
        ticks(26);
        check("rst_pulses", t_edges.size(), 1);
        check("rst_pulse_edge", (t_edges.size() > 0) ? t_edges[0] : -1, 18);
        check("rst_cnt", pulse_cnt, 1);
        btn_in = 1'b0;
        ticks(30);

        // 256 clean presses wrap the counter
        do_reset();
        for (int i = 0; i < 256; i++) begin
            btn_in = 1'b1;
            ticks(40);
            btn_in = 1'b0;
            ticks(40);
            if (i == 254) check("wrap_255", pulse_cnt, 255);
        end
        check("wrap_pulses", t_edges.size(), 256);
        check("wrap_cnt", pulse_cnt, 0);

        // Long hold: high sampled at edges 10..209
        do_reset();
        for (int e = 0; e <= 240; e++) begin
            tick();
            if (ecnt == 9) btn_in = 1'b1;
            if (ecnt == 209) btn_in = 1'b0;
        end
`ifdef AUTO_REPEAT_EN
        exp_edges = '{28, 92, 108, 124, 140, 156, 172, 188, 204};
`else
        exp_edges = '{28};
`endif
        check("hold_pulses", t_edges.size(), exp_edges.size());
        for (int i = 0; i < exp_edges.size(); i++)
            check("hold_edge", (i < t_edges.size()) ? t_edges[i] : -1, exp_edges[i]);
        check("hold_cnt", pulse_cnt, exp_edges.size());
        check("hold_pressed", pressed, 0);
        check("no_back_to_back", back_to_back, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
